// File: rtl/latency_probe.sv
// latency_probe: replays a stored frame to a downstream block over valid/ready,
// then measures the cycles until that block answers on resp_valid. Keeps
// last/min/max latency, a frame count, and sticky timeout / spurious flags.
module latency_probe #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 64,
  parameter int CNT_W   = 16,
  parameter int GAP_W   = 8,
  parameter int TIMEOUT = 1000,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [LW-1:0]     cfg_len,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic [CNT_W-1:0]  cfg_repeat,
  input  logic              start,
  input  logic              abort,
  output logic [DATA_W-1:0] out_byte,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  input  logic              resp_valid,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              spurious_err,
  output logic [CNT_W-1:0]  lat_last,
  output logic [CNT_W-1:0]  lat_min,
  output logic [CNT_W-1:0]  lat_max,
  output logic [CNT_W-1:0]  frames_sent
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_RESP = 2'd2,
    GAP       = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [LW-1:0]    DEPTH_C   = LW'(DEPTH);

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     len_q, len_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]  rep_q, rep_d;
  logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0] out_byte_q, out_byte_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
  logic              timeout_err_q, timeout_err_d;
  logic              spurious_err_q, spurious_err_d;
  logic [CNT_W-1:0]  lat_last_q, lat_last_d;
  logic [CNT_W-1:0]  lat_min_q, lat_min_d;
  logic [CNT_W-1:0]  lat_max_q, lat_max_d;
  logic [CNT_W-1:0]  frames_q, frames_d;

  // Helper terms shared by several FSM branches.
  logic [AW-1:0]     idx_nxt_s;
  logic [LW-1:0]     len_clamped_s;
  logic [CNT_W-1:0]  frames_inc_s;
  logic [CNT_W-1:0]  lat_plus1_s;
  logic              more_after_inc_s;
  logic              more_now_s;
  logic [DATA_W-1:0] first_byte_s;
  logic [DATA_W-1:0] next_byte_s;

  assign idx_nxt_s        = idx_q + AW'(1'b1);
  // A length beyond the buffer would replay stale wrapped entries; cap it.
  assign len_clamped_s    = (cfg_len > DEPTH_C) ? DEPTH_C : cfg_len;
  assign frames_inc_s     = (frames_q == {CNT_W{1'b1}}) ? frames_q : (frames_q + CNT_W'(1'b1));
  assign lat_plus1_s      = lat_cnt_q + CNT_W'(1'b1);
  assign more_after_inc_s = (rep_q == {CNT_W{1'b0}}) || (frames_inc_s < rep_q);
  assign more_now_s       = (rep_q == {CNT_W{1'b0}}) || (frames_q < rep_q);
  assign first_byte_s     = mem[{AW{1'b0}}];
  assign next_byte_s      = mem[idx_nxt_s];

  // Frame buffer: writable only while no run is active.
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == IDLE)) begin
      mem[cfg_addr] <= cfg_data;
    end
  end

  // Next-state, stream output and statistics logic.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    len_d          = len_q;
    gap_d          = gap_q;
    gap_cnt_d      = gap_cnt_q;
    rep_d          = rep_q;
    lat_cnt_d      = lat_cnt_q;
    out_byte_d     = out_byte_q;
    out_valid_d    = out_valid_q;
    out_last_d     = out_last_q;
    done_d         = 1'b0;
    timeout_err_d  = timeout_err_q;
    spurious_err_d = spurious_err_q;
    lat_last_d     = lat_last_q;
    lat_min_d      = lat_min_q;
    lat_max_d      = lat_max_q;
    frames_d       = frames_q;

    if (abort && (state_q != IDLE)) begin
      // Abort beats everything: stop the stream, keep stats, no done pulse.
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (cfg_len != {LW{1'b0}})) begin
            len_d          = len_clamped_s;
            gap_d          = cfg_gap;
            rep_d          = cfg_repeat;
            lat_last_d     = {CNT_W{1'b0}};
            lat_min_d      = {CNT_W{1'b1}};
            lat_max_d      = {CNT_W{1'b0}};
            frames_d       = {CNT_W{1'b0}};
            timeout_err_d  = 1'b0;
            spurious_err_d = 1'b0;
            state_d        = SEND;
            idx_d          = {AW{1'b0}};
            out_byte_d     = first_byte_s;
            out_valid_d    = 1'b1;
            out_last_d     = (len_clamped_s == LW'(1'b1));
          end else if (resp_valid) begin
            spurious_err_d = 1'b1;
          end else begin
            spurious_err_d = spurious_err_q;
          end
        end

        SEND: begin
          if (resp_valid) begin
            spurious_err_d = 1'b1;
          end else begin
            spurious_err_d = spurious_err_q;
          end
          if (out_valid_q && out_ready) begin
            if (out_last_q) begin
              state_d     = WAIT_RESP;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
              lat_cnt_d   = {CNT_W{1'b0}};
            end else begin
              // Prefetch the next byte so out_byte stays a plain register.
              idx_d      = idx_nxt_s;
              out_byte_d = next_byte_s;
              out_last_d = (LW'(idx_nxt_s) == (len_q - LW'(1'b1)));
            end
          end else begin
            out_byte_d = out_byte_q;
          end
        end

        WAIT_RESP: begin
          if (resp_valid || (lat_plus1_s >= TIMEOUT_C)) begin
            frames_d = frames_inc_s;
            if (resp_valid) begin
              lat_last_d = lat_plus1_s;
              lat_min_d  = (lat_plus1_s < lat_min_q) ? lat_plus1_s : lat_min_q;
              lat_max_d  = (lat_plus1_s > lat_max_q) ? lat_plus1_s : lat_max_q;
            end else begin
              timeout_err_d = 1'b1;
            end
            if (gap_q != {GAP_W{1'b0}}) begin
              state_d   = GAP;
              gap_cnt_d = gap_q;
            end else if (more_after_inc_s) begin
              state_d     = SEND;
              idx_d       = {AW{1'b0}};
              out_byte_d  = first_byte_s;
              out_valid_d = 1'b1;
              out_last_d  = (len_q == LW'(1'b1));
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            // Never passes TIMEOUT-1: the timeout branch leaves first.
            lat_cnt_d = lat_plus1_s;
          end
        end

        GAP: begin
          if (resp_valid) begin
            spurious_err_d = 1'b1;
          end else begin
            spurious_err_d = spurious_err_q;
          end
          if (gap_cnt_q <= GAP_W'(1'b1)) begin
            if (more_now_s) begin
              state_d     = SEND;
              idx_d       = {AW{1'b0}};
              out_byte_d  = first_byte_s;
              out_valid_d = 1'b1;
              out_last_d  = (len_q == LW'(1'b1));
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1'b1);
          end
        end

        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= {AW{1'b0}};
      len_q          <= {LW{1'b0}};
      gap_q          <= {GAP_W{1'b0}};
      gap_cnt_q      <= {GAP_W{1'b0}};
      rep_q          <= {CNT_W{1'b0}};
      lat_cnt_q      <= {CNT_W{1'b0}};
      out_byte_q     <= {DATA_W{1'b0}};
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      done_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      spurious_err_q <= 1'b0;
      lat_last_q     <= {CNT_W{1'b0}};
      lat_min_q      <= {CNT_W{1'b1}};
      lat_max_q      <= {CNT_W{1'b0}};
      frames_q       <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
      gap_q          <= gap_d;
      gap_cnt_q      <= gap_cnt_d;
      rep_q          <= rep_d;
      lat_cnt_q      <= lat_cnt_d;
      out_byte_q     <= out_byte_d;
      out_valid_q    <= out_valid_d;
      out_last_q     <= out_last_d;
      done_q         <= done_d;
      timeout_err_q  <= timeout_err_d;
      spurious_err_q <= spurious_err_d;
      lat_last_q     <= lat_last_d;
      lat_min_q      <= lat_min_d;
      lat_max_q      <= lat_max_d;
      frames_q       <= frames_d;
    end
  end

  assign out_byte     = out_byte_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign timeout_err  = timeout_err_q;
  assign spurious_err = spurious_err_q;
  assign lat_last     = lat_last_q;
  assign lat_min      = lat_min_q;
  assign lat_max      = lat_max_q;
  assign frames_sent  = frames_q;

endmodule

// File: doc/latency_probe.md
LATENCY_PROBE -- requirements
Module: latency_probe

Interface
REQ-001 Parameter: DATA_W, 8, stream byte width.
REQ-002 Parameter: DEPTH, 64, frame buffer entries; AW = $clog2(DEPTH), LW = $clog2(DEPTH+1).
REQ-003 Parameter: CNT_W, 16, width of latency, repeat and frame counters.
REQ-004 Parameter: GAP_W, 8, inter-frame gap counter width.
REQ-005 Parameter: TIMEOUT, 1000, max cycles to wait for a response (2..2^CNT_W-1).
REQ-006 Ports: clk  in  1  single clock, all logic on rising edge.
REQ-007 Ports: rst  in  1  asynchronous, active-high reset.
REQ-008 Ports: cfg_we in 1, cfg_addr in AW, cfg_data in DATA_W  frame buffer write.
REQ-009 Ports: cfg_len in LW, cfg_gap in GAP_W, cfg_repeat in CNT_W  frame length, idle cycles between frames, frame count (0 = continuous).
REQ-010 Ports: start in 1, abort in 1  single-cycle run control.
REQ-011 Ports: out_byte out DATA_W, out_valid out 1, out_last out 1, out_ready in 1  stream to DUT (valid/ready).
REQ-012 Ports: resp_valid in 1  DUT response strobe (e.g. order/UART start).
REQ-013 Ports: busy out 1, done out 1 (one-cycle pulse), timeout_err out 1, spurious_err out 1 (sticky).
REQ-014 Ports: lat_last, lat_min, lat_max, frames_sent out CNT_W each  statistics.

Function
REQ-015 FSM states IDLE, SEND, WAIT_RESP, GAP; busy = (state != IDLE).
REQ-016 cfg_we writes buffer[cfg_addr] only in IDLE; ignored otherwise.
REQ-017 IDLE: start with cfg_len != 0 -> SEND next cycle, index = 0, repeat count latched, stats cleared (lat_min = all ones, lat_max = 0, lat_last = 0, frames_sent = 0), sticky errors cleared.
REQ-018 start with cfg_len == 0, or start while busy: ignored.
REQ-019 SEND: out_valid = 1, out_byte = buffer[index] (registered, no combinational path from out_ready to out_byte), out_last = (index == cfg_len-1).
REQ-020 Byte accepted when out_valid && out_ready; index advances only on acceptance; out_byte/out_valid held stable while out_ready low.
REQ-021 Last byte accepted -> WAIT_RESP; latency counter cleared to 0 in that cycle, increments by 1 each subsequent cycle.
REQ-022 WAIT_RESP: resp_valid high -> lat_last = counter+1 (response on the cycle after last acceptance gives 1), lat_min/lat_max updated in the same cycle, frames_sent +1, -> GAP.
REQ-023 WAIT_RESP: counter+1 reaches TIMEOUT without resp_valid -> timeout_err set, frames_sent +1, lat stats untouched, -> GAP.
REQ-024 resp_valid in IDLE, SEND or GAP -> spurious_err set; no state change.
REQ-025 GAP: wait cfg_gap cycles (0 = go directly), then SEND if more frames remain, else IDLE with done pulsed for one cycle.
REQ-026 Frames remaining: cfg_repeat == 0 runs until abort; else stop after frames_sent == latched repeat.
REQ-027 frames_sent saturates at 2^CNT_W-1; latency counter saturates (cannot exceed TIMEOUT).
REQ-028 abort in any busy state -> IDLE next cycle, out_valid low, stats and errors retained, done not pulsed; abort has priority over start and resp_valid.
REQ-029 cfg_len/cfg_gap sampled at start and held for the run.

Reset
REQ-030 On rst: state IDLE, out_valid = 0, out_last = 0, out_byte = 0, busy = 0, done = 0, errors = 0, lat_last = 0, lat_max = 0, lat_min = all ones, frames_sent = 0.
REQ-031 rst asserted mid-frame drops out_valid immediately (asynchronous); buffer contents need not be reset.
REQ-032 After rst release, the first start is honoured on the first clk edge.

Verification
REQ-033 Load 4 bytes 0xA1..0xA4, len 4, repeat 1, gap 0, out_ready=1, resp_valid 3 cycles after last byte -> bytes in order, out_last on 0xA4, lat_last=lat_min=lat_max=3, frames_sent=1, done pulse.
REQ-034 out_ready toggled 1/0 each cycle during SEND -> each byte held until accepted, no byte dropped or repeated.
REQ-035 repeat 3, gap 5, responses at latencies 2, 7, 4 -> lat_min=2, lat_max=7, lat_last=4, frames_sent=3, >=5 idle cycles between frames.
REQ-036 TIMEOUT=20, no response -> timeout_err=1 after 20 cycles, frames_sent=1, lat_min stays all ones.
REQ-037 resp_valid during SEND -> spurious_err=1; abort mid-frame -> out_valid low next cycle, busy=0, no done; rst mid-frame -> all outputs at reset values.
